// File: rtl/rpi_mmu_pkg.sv
// rpi_mmu_pkg: shared widths and in-flight read slot type
// for the RPi-SPI memory map.
package rpi_mmu_pkg;

    localparam int CHIP_W  = 8;
    localparam int OFFS_W  = 16;
    localparam int DATA_W  = 32;
    localparam int STATS_N = 4;

    localparam logic [CHIP_W-1:0] STATS_CHIP = 8'hFF;

    typedef struct packed {
        logic              valid;
        logic [CHIP_W-1:0] chip;
        logic              stats;
    } rd_slot_t;

endpackage

// File: rtl/rpi_mmu_rd_pipe.sv
// rpi_mmu_rd_pipe: fixed-depth shift register of read slots,
// flushed synchronously by rst.
module rpi_mmu_rd_pipe
    import rpi_mmu_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rd_slot_t in_slot,
    output rd_slot_t out_slot
);

    rd_slot_t sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= in_slot;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign out_slot = sr[DEPTH-1];

endmodule

// File: rtl/rpi_mmu_nchan.sv
// rpi_mmu_nchan: SPI bus address map onto NUM_CHIPS memory channels.
// Define RPI_MMU_NCHAN_STATS_EN for a read-only stats window at chip 8'hFF.
module rpi_mmu_nchan
    import rpi_mmu_pkg::*;
#(
    parameter int NUM_CHIPS = 4,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rpi_we,
    input  logic                        rpi_re,
    input  logic [CHIP_W+OFFS_W-1:0]    rpi_addr,
    input  logic [DATA_W-1:0]           rpi_wd,
    output logic [DATA_W-1:0]           rpi_rd,
    output logic                        rpi_rd_valid,
    output logic [OFFS_W-1:0]           chip_addr,
    output logic [DATA_W-1:0]           chip_wd,
    output logic [NUM_CHIPS-1:0]        chip_we,
    output logic [NUM_CHIPS-1:0]        chip_re,
    input  logic [NUM_CHIPS*DATA_W-1:0] chip_rd,
    input  logic                        err_clear,
    output logic                        err_unmapped,
    output logic                        err_collision
);

    logic [CHIP_W-1:0]    chip;
    logic [OFFS_W-1:0]    offs;
    logic                 mapped;
    logic                 is_stats;
    logic                 unmapped;
    logic                 collision;
    logic                 do_rd;
    logic [NUM_CHIPS-1:0] sel;
    rd_slot_t             issue;
    rd_slot_t             head;
    logic [DATA_W-1:0]    rd_data;
    logic [DATA_W-1:0]    rd_hold;

    assign chip      = rpi_addr[CHIP_W+OFFS_W-1:OFFS_W];
    assign offs      = rpi_addr[OFFS_W-1:0];
    assign mapped    = int'(chip) < NUM_CHIPS;
`ifdef RPI_MMU_NCHAN_STATS_EN
    assign is_stats  = chip == STATS_CHIP;
`else
    assign is_stats  = 1'b0;
`endif
    assign unmapped  = (rpi_we | rpi_re) & ~mapped & ~is_stats;
    assign collision = rpi_we & rpi_re;
    assign do_rd     = rpi_re & ~rpi_we;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            sel[i] = mapped && (int'(chip) == i);
        end
    end

    // Stats slots reuse the chip field to carry the counter index.
    always_comb begin
        issue       = '0;
        issue.valid = do_rd;
        issue.stats = is_stats;
        issue.chip  = is_stats ? {6'b0, offs[1:0]} : chip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chip_addr     <= '0;
            chip_wd       <= '0;
            chip_we       <= '0;
            chip_re       <= '0;
            err_unmapped  <= 1'b0;
            err_collision <= 1'b0;
            rd_hold       <= '0;
        end else begin
            if (rpi_we | rpi_re) begin
                chip_addr <= offs;
            end
            if (rpi_we) begin
                chip_wd <= rpi_wd;
            end
            chip_we       <= rpi_we ? sel : '0;
            chip_re       <= do_rd  ? sel : '0;
            err_unmapped  <= unmapped  | (err_unmapped  & ~err_clear);
            err_collision <= collision | (err_collision & ~err_clear);
            if (head.valid) begin
                rd_hold <= rd_data;
            end
        end
    end

    // One extra stage aligns the slot with the registered chip_re.
    rpi_mmu_rd_pipe #(
        .DEPTH    (RD_LAT + 1)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_slot  (issue),
        .out_slot (head)
    );

`ifdef RPI_MMU_NCHAN_STATS_EN
    logic [DATA_W-1:0]  stat_cnt [STATS_N];
    logic [STATS_N-1:0] stat_ev;

    assign stat_ev = {collision, unmapped,
                      do_rd & mapped, rpi_we & mapped};

    always_ff @(posedge clk) begin
        for (int i = 0; i < STATS_N; i++) begin
            if (rst || err_clear) begin
                stat_cnt[i] <= '0;
            end else if (stat_ev[i] && (stat_cnt[i] != '1)) begin
                stat_cnt[i] <= stat_cnt[i] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_CHIPS; i++) begin
            if (int'(head.chip) == i) begin
                rd_data = chip_rd[DATA_W*i +: DATA_W];
            end
        end
        if (head.stats) begin
`ifdef RPI_MMU_NCHAN_STATS_EN
            rd_data = stat_cnt[head.chip[1:0]];
`else
            rd_data = '0;
`endif
        end
    end

    assign rpi_rd_valid = head.valid;
    assign rpi_rd       = head.valid ? rd_data : rd_hold;

endmodule
